// File: rtl/fpaddsub_arbiter.sv
// Round-robin arbiter sharing one IEEE fpaddsub among NREQ requesters.
// Define FPADDSUB_ARB_PIPE_EN to register operands ahead of fpaddsub.
module fpaddsub #(
  parameter int LOG_BIT = 6,
  parameter int EXP_BIT = 11
) (
  input  logic [2**LOG_BIT-1:0] a_i,
  input  logic [2**LOG_BIT-1:0] b_i,
  input  logic                  addnot_sub_i,
  output logic [2**LOG_BIT-1:0] y_o
);
  localparam int W  = 2**LOG_BIT;
  localparam int E  = EXP_BIT;
  localparam int M  = W - E - 1;
  localparam int N  = M + 4;
  localparam int XW = E + 2;

  logic          sa, sb, sx, sy, swp, esub, stk, rup, rs;
  logic          nan, inf;
  logic [E-1:0]  ea, eb;
  logic [M-1:0]  fa, fb, fr;
  logic [XW-1:0] ex, ey, d, lz, e_n, e_r;
  logic [N-1:0]  mx, my, sh, nrm;
  logic [N:0]    sum;
  logic [M+1:0]  rnd;

  always_comb begin
    sa = a_i[W-1];
    ea = a_i[W-2:M];
    fa = a_i[M-1:0];
    sb = b_i[W-1] ^ ~addnot_sub_i;
    eb = b_i[W-2:M];
    fb = b_i[M-1:0];
    swp = {eb, fb} > {ea, fa};
    sx = swp ? sb : sa;
    sy = swp ? sa : sb;
    ex = {2'b0, swp ? eb : ea};
    ey = {2'b0, swp ? ea : eb};
    mx = {ex != '0, swp ? fb : fa, 3'b000};
    my = {ey != '0, swp ? fa : fb, 3'b000};
    // subnormals share the exponent of the smallest normal
    if (ex == '0) ex = XW'(1);
    if (ey == '0) ey = XW'(1);
    d = ex - ey;
    if (d >= XW'(N)) begin
      sh  = '0;
      stk = |my;
    end else begin
      sh  = my >> d;
      stk = |(my & ~({N{1'b1}} << d));
    end
    sh[0] = sh[0] | stk;
    esub = sx ^ sy;
    sum = esub ? {1'b0, mx} - {1'b0, sh}
               : {1'b0, mx} + {1'b0, sh};
    lz = XW'(N);
    for (int i = 0; i < N; i++)
      if (sum[i]) lz = XW'(N - 1 - i);
    if (sum[N]) begin
      nrm = sum[N:1] | {{(N-1){1'b0}}, sum[0]};
      e_n = ex + XW'(1);
    end else begin
      if (lz >= ex) lz = ex - XW'(1);
      nrm = sum[N-1:0] << lz;
      e_n = ex - lz;
    end
    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd = {1'b0, nrm[N-1:3]} + (M+2)'(rup);
    if (rnd[M+1]) begin
      e_r = e_n + XW'(1);
      fr  = rnd[M:1];
    end else begin
      e_r = rnd[M] ? e_n : '0;
      fr  = rnd[M-1:0];
    end
    rs  = (sum == '0) ? (sx & sy) : sx;
    nan = (&ea & |fa) | (&eb & |fb) | (&ea & &eb & (sa ^ sb));
    inf = &ea | &eb;
    if (nan)
      y_o = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    else if (inf)
      y_o = {(&ea ? sa : sb), {E{1'b1}}, {M{1'b0}}};
    else if (e_r >= XW'({E{1'b1}}))
      y_o = {rs, {E{1'b1}}, {M{1'b0}}};
    else
      y_o = {rs, e_r[E-1:0], fr};
  end
endmodule

module fpaddsub_arbiter #(
  parameter int LOG_BIT = 6,
  parameter int EXP_BIT = 11,
  parameter int NREQ    = 4,
  localparam int W      = 2**LOG_BIT,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_addnot_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id
);
  logic [IDW-1:0] ptr_q, ptr_d, gnt_idx, rsp_id_q;
  logic           gnt_any, s1_adv, s2_adv, acc;
  logic           rsp_valid_q, mux_add, fp_add;
  logic [W-1:0]   rsp_data_q, mux_a, mux_b;
  logic [W-1:0]   fp_a, fp_b, fp_y;

  always_comb begin
    int j;
    j = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0
               : gnt_idx + 1'b1;
  assign mux_a   = req_a[gnt_idx*W +: W];
  assign mux_b   = req_b[gnt_idx*W +: W];
  assign mux_add = req_addnot_sub[gnt_idx];
  assign s2_adv  = !rsp_valid_q || rsp_ready;

`ifdef FPADDSUB_ARB_PIPE_EN
  logic           op_v_q, op_add_q;
  logic [W-1:0]   op_a_q, op_b_q;
  logic [IDW-1:0] op_id_q;
  assign s1_adv = !op_v_q || s2_adv;
  assign fp_a   = op_a_q;
  assign fp_b   = op_b_q;
  assign fp_add = op_add_q;
`else
  assign s1_adv = s2_adv;
  assign fp_a   = mux_a;
  assign fp_b   = mux_b;
  assign fp_add = mux_add;
`endif

  assign acc = !rst && s1_adv && gnt_any;

  always_comb begin
    req_ready = '0;
    if (acc) req_ready[gnt_idx] = 1'b1;
  end

  fpaddsub #(
    .LOG_BIT(LOG_BIT),
    .EXP_BIT(EXP_BIT)
  ) u_fp (
    .a_i         (fp_a),
    .b_i         (fp_b),
    .addnot_sub_i(fp_add),
    .y_o         (fp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef FPADDSUB_ARB_PIPE_EN
      op_v_q      <= 1'b0;
      op_add_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
`endif
    end else begin
      if (acc) ptr_q <= ptr_d;
`ifdef FPADDSUB_ARB_PIPE_EN
      if (s1_adv) begin
        op_v_q <= acc;
        if (acc) begin
          op_a_q   <= mux_a;
          op_b_q   <= mux_b;
          op_add_q <= mux_add;
          op_id_q  <= gnt_idx;
        end
      end
      if (s2_adv) begin
        rsp_valid_q <= op_v_q;
        if (op_v_q) begin
          rsp_data_q <= fp_y;
          rsp_id_q   <= op_id_q;
        end
      end
`else
      if (s2_adv) begin
        rsp_valid_q <= acc;
        if (acc) begin
          rsp_data_q <= fp_y;
          rsp_id_q   <= gnt_idx;
        end
      end
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Randomized bench for fpaddsub_arbiter against a
// slot-level model using the simulator's double arithmetic.
module tb_fpaddsub_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;
`ifdef FPADDSUB_ARB_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_addnot_sub = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;

  fpaddsub_arbiter #(
    .LOG_BIT(6),
    .EXP_BIT(11),
    .NREQ   (NREQ)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_addnot_sub(req_addnot_sub),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] ra [NREQ];
  logic [63:0] rb [NREQ];
  logic        rop [NREQ];
  int          ptr_m;
  bit          mv [L];
  logic [63:0] md [L];
  int          mid [L];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fp_ref(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic add);
    real x, y;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    return add ? $realtobits(x + y) : $realtobits(x - y);
  endfunction

  function automatic logic [63:0] rnd_fp();
    logic [63:0] v;
    logic [31:0] lo, hi;
    lo = $urandom;
    hi = $urandom;
    v = {hi, lo};
    v[62:52] = 11'($urandom_range(960, 1080));
    if ($urandom_range(0, 15) == 0) v[62:0] = '0;
    return v;
  endfunction

  task automatic model_clear();
    ptr_m = 0;
    for (int k = 0; k < L; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
      mid[k] = 0;
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] er;
    bit ld [L];
    bit acc;
    int g, j;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
      req_addnot_sub[i] = rop[i];
    end
    #1;
    ld[L-1] = !mv[L-1] || rsp_ready;
    for (int k = L - 2; k >= 0; k--) ld[k] = !mv[k] || ld[k+1];
    acc = 1'b0;
    g = 0;
    if (!rst && ld[0])
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr_m + k) % NREQ;
        if (!acc && req_valid[j]) begin
          acc = 1'b1;
          g = j;
        end
      end
    er = '0;
    if (acc) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, mv[L-1]);
    if (mv[L-1]) begin
      chk("rsp_data", rsp_data, md[L-1]);
      chk("rsp_id", rsp_id, mid[L-1]);
    end
    @(posedge clk);
    if (rst) model_clear();
    else begin
      for (int k = L - 1; k >= 1; k--)
        if (ld[k]) begin
          mv[k] = mv[k-1];
          md[k] = md[k-1];
          mid[k] = mid[k-1];
        end
      if (ld[0]) begin
        mv[0] = acc;
        if (acc) begin
          md[0] = fp_ref(ra[g], rb[g], rop[g]);
          mid[0] = g;
        end
      end
      if (acc) ptr_m = (g + 1) % NREQ;
    end
    @(negedge clk);
  endtask

  task automatic new_ops(input int i);
    ra[i] = rnd_fp();
    rb[i] = ($urandom_range(0, 7) == 0) ? ra[i] : rnd_fp();
    rop[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) new_ops(i);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    chk("rst_data", rsp_data, 64'h0);
    chk("rst_id", rsp_id, 64'h0);
    rst = 1'b0;

    ra[0] = 64'h3FF0000000000000;
    rb[0] = 64'h4000000000000000;
    rop[0] = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (L - 1) step();
    chk("single_data", rsp_data, 64'h4008000000000000);
    chk("single_id", rsp_id, 64'd0);
    step();

    ra[2] = 64'h4014000000000000;
    rb[2] = 64'h4008000000000000;
    rop[2] = 1'b0;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (L - 1) step();
    chk("sub_data", rsp_data, 64'h4000000000000000);
    chk("sub_id", rsp_id, 64'd2);
    step();

    req_valid = 4'b1000;
    step();
    req_valid = 4'b0010;
    #1 chk("ptr0_gnt1", req_ready, 64'b0010);
    step();
    req_valid = 4'b0011;
    #1 chk("ptr2_gnt0", req_ready, 64'b0001);
    step();

    req_valid = 4'b1111;
    step();
    rsp_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b0110;
    #1 chk("rst_drop", rsp_valid, 64'd0);
    chk("rst_lowest", req_ready, 64'b0010);
    rsp_ready = 1'b1;
    step();
    repeat (L + 1) step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) new_ops(i);
      #1 chk("rr_order", req_ready, 64'(1 << (k % NREQ)));
      step();
    end

    rsp_ready = 1'b0;
    repeat (5) step();
    rsp_ready = 1'b1;
    repeat (4) step();

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 1) == 1) new_ops(i);
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (L + 1) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
